// File: rtl/spi_slave_if.sv
// Pin-side and local-side signal bundle for the SPI mode-0 slave endpoint.
// The slave modport is the endpoint's view; the master modport is the view of whatever drives the pins and the local handshakes.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              sck_in;
  logic              mosi;
  logic              cs_n;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_ovr;
  logic              busy;

  modport slave (
    input  sck_in, mosi, cs_n, tx_data, tx_wr, rx_ack,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_ovr, busy
  );

  modport master (
    output sck_in, mosi, cs_n, tx_data, tx_wr, rx_ack,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_ovr, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sck/mosi/cs_n with clk, deserialises MSB-first frames
// into rx_data and serialises a queued transmit word (or all-ones) onto miso.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  spi_slave_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic              sck_s1, sck_s2, sck_s3;
  logic              cs_s1, cs_s2, cs_s3;
  logic              mosi_s1, mosi_s2;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf, rx_data_q, rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              frame_done, tx_ready_q, rx_valid_q, rx_ovr_q;
  logic              sck_rise, sck_fall, cs_start, cs_end, do_load;

  // Synchronisers reset to the idle bus levels so that leaving reset never fakes an edge.
  // NOTE: registers are updated with <= so every flop samples the pre-edge value of its source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {sck_s1, sck_s2, sck_s3} <= 3'b000;
      {cs_s1, cs_s2, cs_s3}    <= 3'b111;
      {mosi_s1, mosi_s2}       <= 2'b11;
    end else begin
      {sck_s1, sck_s2, sck_s3} <= {bus.sck_in, sck_s1, sck_s2};
      {cs_s1, cs_s2, cs_s3}    <= {bus.cs_n, cs_s1, cs_s2};
      {mosi_s1, mosi_s2}       <= {bus.mosi, mosi_s1};
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;
  assign cs_start = ~cs_s2 & cs_s3;
  assign cs_end   = cs_s2 & ~cs_s3;
  assign rx_next  = {rx_shift[DATA_W-2:0], mosi_s2};

  // A load happens at select, and on the first falling sck after a completed frame.
  assign do_load = ((state == IDLE) && cs_start) ||
                   ((state == ACTIVE) && !cs_end && sck_fall && frame_done);

  // NOTE: tx_buf is pure datapath with no reset; it is only read while tx_ready_q is low,
  // which guarantees it was written first.
  always_ff @(posedge clk) begin
    if (bus.tx_wr && tx_ready_q) tx_buf <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rx_shift   <= '1;
      tx_shift   <= '1;
      rx_data_q  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end

      // The load sees the old buffer state; a coincident write is captured afterwards.
      if (do_load) begin
        tx_shift   <= tx_ready_q ? '1 : tx_buf;
        tx_ready_q <= 1'b1;
      end
      if (bus.tx_wr && tx_ready_q) tx_ready_q <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_start) begin
            state      <= ACTIVE;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_end) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              rx_ovr_q   <= !bus.rx_ack && (rx_ovr_q || rx_valid_q);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (frame_done) frame_done <= 1'b0;
            else            tx_shift   <= {tx_shift[DATA_W-2:0], 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.miso     = tx_shift[DATA_W-1];
  assign bus.miso_oe  = ~cs_s2;
  assign bus.busy     = (state == ACTIVE);
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives the pins on the
// falling clk edge and all outputs are sampled there, half a period from the active edge.
module tb_spi_slave;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;
  logic [7:0] mi;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk); bus.rx_ack = 1'b1;
    @(negedge clk); bus.rx_ack = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk); bus.tx_data = d; bus.tx_wr = 1'b1;
    @(negedge clk); bus.tx_wr = 1'b0;
  endtask

  // One mode-0 frame: mosi changes in the low phase, miso is sampled just before each rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int half,
                      input bit do_start, input bit do_end, input bit chk_lat,
                      input bit ack_done, input bit wr_mid, input logic [7:0] wr_byte,
                      output logic [7:0] mo_seen);
    mo_seen = 8'h00;
    if (do_start) begin
      bus.cs_n = 1'b0;
      repeat (4) @(negedge clk);
      if (wr_mid) begin
        bus.tx_data = wr_byte; bus.tx_wr = 1'b1;
        @(negedge clk); bus.tx_wr = 1'b0;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      repeat (half) @(negedge clk);
      mo_seen[7-i] = bus.miso;
      bus.sck_in = 1'b1;
      if (i == 7 && (chk_lat || ack_done)) begin
        repeat (2) @(negedge clk);
        if (chk_lat) check("rx_valid_before_e2", bus.rx_valid, 1'b0);
        if (ack_done) bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        if (chk_lat) check("rx_valid_after_e2", bus.rx_valid, 1'b1);
        repeat (half - 3) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      bus.sck_in = 1'b0;
    end
    repeat (half) @(negedge clk);
    if (do_end) begin
      bus.cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  logic [7:0] sw_mo   [4] = '{8'hC3, 8'h96, 8'h0F, 8'hE7};
  logic [7:0] sw_mi   [4] = '{8'h3E, 8'h71, 8'hF0, 8'h18};
  int         sw_half [4] = '{4, 5, 6, 7};

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst         = 1'b0;
    bus.sck_in  = 1'b0;
    bus.cs_n    = 1'b1;
    bus.mosi    = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_wr   = 1'b0;
    bus.rx_ack  = 1'b0;

    // Reset held while every input toggles.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.sck_in  = ~bus.sck_in;
      bus.cs_n    = i[1];
      bus.mosi    = i[0];
      bus.tx_wr   = 1'b1;
      bus.tx_data = 8'(i * 37);
      bus.rx_ack  = i[2];
    end
    check("rst_miso",     bus.miso,     1'b1);
    check("rst_miso_oe",  bus.miso_oe,  1'b0);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_ovr",   bus.rx_ovr,   1'b0);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_rx_data",  bus.rx_data,  8'h00);

    @(negedge clk);
    bus.sck_in = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b1;
    bus.tx_wr = 1'b0; bus.rx_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (4) @(negedge clk);
      bus.sck_in = ~bus.sck_in;
    end
    repeat (4) @(negedge clk);
    check("idle_busy",     bus.busy,     1'b0);
    check("idle_rx_valid", bus.rx_valid, 1'b0);
    check("idle_miso_oe",  bus.miso_oe,  1'b0);
    check("idle_miso",     bus.miso,     1'b1);

    // Basic transfer: slave sends 0xA5, master sends 0x3C.
    write_tx(8'hA5);
    check("basic_tx_ready_queued", bus.tx_ready, 1'b0);
    xfer(8'h3C, 8, 4, 1, 1, 1, 0, 0, 8'h00, mi);
    check("basic_miso_bits", mi,           8'hA5);
    check("basic_rx_data",   bus.rx_data,  8'h3C);
    check("basic_rx_valid",  bus.rx_valid, 1'b1);
    check("basic_rx_ovr",    bus.rx_ovr,   1'b0);
    check("basic_tx_ready",  bus.tx_ready, 1'b1);
    ack_pulse();
    check("basic_ack_valid", bus.rx_valid, 1'b0);

    // Back-to-back frames, nothing queued, no ack in between.
    xfer(8'h01, 8, 4, 1, 0, 0, 0, 0, 8'h00, mi);
    check("b2b_miso_f1",   mi,           8'hFF);
    check("b2b_busy",      bus.busy,     1'b1);
    check("b2b_miso_oe",   bus.miso_oe,  1'b1);
    check("b2b_valid_f1",  bus.rx_valid, 1'b1);
    check("b2b_ovr_f1",    bus.rx_ovr,   1'b0);
    xfer(8'h02, 8, 4, 0, 1, 0, 0, 0, 8'h00, mi);
    check("b2b_miso_f2",   mi,           8'hFF);
    check("b2b_rx_data",   bus.rx_data,  8'h02);
    check("b2b_rx_valid",  bus.rx_valid, 1'b1);
    check("b2b_rx_ovr",    bus.rx_ovr,   1'b1);
    check("b2b_busy_end",  bus.busy,     1'b0);
    ack_pulse();
    check("b2b_ack_valid", bus.rx_valid, 1'b0);
    check("b2b_ack_ovr",   bus.rx_ovr,   1'b0);

    // Ack lands on the completion edge of frame 2: the new frame wins.
    xfer(8'h11, 8, 4, 1, 0, 0, 0, 0, 8'h00, mi);
    xfer(8'h22, 8, 4, 0, 1, 0, 1, 0, 8'h00, mi);
    check("coll_rx_valid", bus.rx_valid, 1'b1);
    check("coll_rx_ovr",   bus.rx_ovr,   1'b0);
    check("coll_rx_data",  bus.rx_data,  8'h22);
    ack_pulse();

    // Abort after 5 bits; a write made during the aborted frame stays queued.
    xfer(8'hFF, 5, 4, 1, 1, 0, 0, 1, 8'h5A, mi);
    check("abort_rx_valid", bus.rx_valid, 1'b0);
    check("abort_rx_data",  bus.rx_data,  8'h22);
    check("abort_tx_ready", bus.tx_ready, 1'b0);
    check("abort_busy",     bus.busy,     1'b0);
    xfer(8'h81, 8, 4, 1, 1, 0, 0, 0, 8'h00, mi);
    check("post_abort_rx_data",  bus.rx_data,  8'h81);
    check("post_abort_rx_valid", bus.rx_valid, 1'b1);
    check("post_abort_miso",     mi,           8'h5A);
    check("post_abort_tx_ready", bus.tx_ready, 1'b1);
    ack_pulse();

    // Sweep of sck half-periods with data both ways, acked every frame.
    for (int k = 0; k < 4; k++) begin
      write_tx(sw_mi[k]);
      xfer(sw_mo[k], 8, sw_half[k], 1, 1, 0, 0, 0, 8'h00, mi);
      check($sformatf("sweep%0d_rx_data", k), bus.rx_data, sw_mo[k]);
      check($sformatf("sweep%0d_miso", k),    mi,          sw_mi[k]);
      check($sformatf("sweep%0d_rx_ovr", k),  bus.rx_ovr,  1'b0);
      ack_pulse();
    end

    // Reset asserted mid-frame takes effect without waiting for a clock.
    write_tx(8'h77);
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_pre_busy", bus.busy, 1'b1);
    check("midrst_pre_miso", bus.miso, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_busy",     bus.busy,     1'b0);
    check("midrst_miso",     bus.miso,     1'b1);
    check("midrst_miso_oe",  bus.miso_oe,  1'b0);
    check("midrst_tx_ready", bus.tx_ready, 1'b1);
    check("midrst_rx_data",  bus.rx_data,  8'h00);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_idle_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
